// File: rtl/pbridge_pkg.sv
// Shared types and constants for the peripheral bus bridge (state encoding,
// slot geometry, bus-error read pattern).
package pbridge_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACCESS  = 2'd1,
        CAPTURE = 2'd2,
        DONE    = 2'd3
    } pbridge_state_e;

    localparam int          SLOT_ADDR_BITS = 11;
    localparam logic [31:0] BUSERR_RDATA   = 32'hDEAD_BEEF;

    // Width of a slot index; a single-slot build still carries one bit.
    function automatic int slot_w(input int nslots);
        return (nslots > 1) ? $clog2(nslots) : 1;
    endfunction

endpackage

// File: rtl/pbridge_addr_decode.sv
// Combinational decode of a CPU byte address into a peripheral slot index
// and an in-window flag.
module pbridge_addr_decode
    import pbridge_pkg::*;
#(
    parameter int          NSLOTS    = 4,
    parameter logic [31:0] BASE_ADDR = 32'h8000_0000
) (
    input  logic [31:0]                cpu_addr,
    output logic [slot_w(NSLOTS)-1:0]  slot_idx,
    output logic                       in_range
);

    localparam int SLOT_W = slot_w(NSLOTS);
    localparam logic [31:0] WINDOW_BYTES = 32'(NSLOTS) << SLOT_ADDR_BITS;

    logic [31:0] offset_s;

    // Addresses below the base wrap to a huge offset and so fall out of range.
    always_comb begin
        offset_s = cpu_addr - BASE_ADDR;
        in_range = (offset_s < WINDOW_BYTES);
        slot_idx = offset_s[SLOT_ADDR_BITS +: SLOT_W];
    end

endmodule

// File: rtl/periph_bus_bridge.sv
// Bridges one CPU load/store to a single-cycle peripheral slot access with a
// fixed 3-cycle latency. Define PBRIDGE_BUSERR_EN to flag unmapped accesses.
module periph_bus_bridge
    import pbridge_pkg::*;
#(
    parameter int          NSLOTS    = 4,
    parameter logic [31:0] BASE_ADDR = 32'h8000_0000
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [31:0]               cpu_addr,
    input  logic [31:0]               cpu_wdata,
    input  logic                      cpu_rden,
    input  logic                      cpu_wren,
    output logic [31:0]               cpu_rdata,
    output logic                      cpu_ready,
    output logic                      cpu_err,
    output logic [SLOT_ADDR_BITS-1:0] periph_address,
    output logic [31:0]               periph_data,
    output logic                      periph_rden,
    output logic                      periph_wren,
    output logic [NSLOTS-1:0]         periph_clken,
    input  logic [NSLOTS*32-1:0]      periph_q
);

    localparam int SLOT_W = slot_w(NSLOTS);

`ifdef PBRIDGE_BUSERR_EN
    localparam logic        ERR_EN_P       = 1'b1;
    localparam logic [31:0] UNMAPPED_RDATA = BUSERR_RDATA;
`else
    localparam logic        ERR_EN_P       = 1'b0;
    localparam logic [31:0] UNMAPPED_RDATA = 32'h0000_0000;
`endif

    pbridge_state_e    state_r;
    logic [SLOT_W-1:0] slot_r;
    logic              mapped_r;
    logic              is_read_r;
    logic [NSLOTS-1:0] clken_r;

    logic [SLOT_W-1:0] dec_slot_s;
    logic              dec_in_range_s;
    logic [NSLOTS-1:0] onehot_s;
    logic [31:0]       q_sel_s;

    pbridge_addr_decode #(
        .NSLOTS    (NSLOTS),
        .BASE_ADDR (BASE_ADDR)
    ) u_decode (
        .cpu_addr  (cpu_addr),
        .slot_idx  (dec_slot_s),
        .in_range  (dec_in_range_s)
    );

    // One-hot slot enable for the request being accepted; empty when unmapped.
    always_comb begin
        onehot_s = {NSLOTS{1'b0}};
        for (int i = 0; i < NSLOTS; i++) begin
            onehot_s[i] = dec_in_range_s & (dec_slot_s == SLOT_W'(i));
        end
    end

    // Read-data mux selecting the latched slot's q.
    always_comb begin
        q_sel_s = 32'h0000_0000;
        for (int i = 0; i < NSLOTS; i++) begin
            q_sel_s = (slot_r == SLOT_W'(i)) ? periph_q[32*i +: 32] : q_sel_s;
        end
    end

    // Reset masks the slot enables immediately so an in-flight access never lands.
    assign periph_clken = clken_r & {NSLOTS{~rst}};

    // Access sequencer: IDLE -> ACCESS -> CAPTURE -> DONE, all outputs registered.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r        <= IDLE;
            slot_r         <= {SLOT_W{1'b0}};
            mapped_r       <= 1'b0;
            is_read_r      <= 1'b0;
            clken_r        <= {NSLOTS{1'b0}};
            periph_address <= {SLOT_ADDR_BITS{1'b0}};
            periph_data    <= 32'h0000_0000;
            periph_rden    <= 1'b0;
            periph_wren    <= 1'b0;
            cpu_rdata      <= 32'h0000_0000;
            cpu_ready      <= 1'b0;
            cpu_err        <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (cpu_rden | cpu_wren) begin
                        // A simultaneous load and store is treated as a store.
                        periph_address <= cpu_addr[SLOT_ADDR_BITS-1:0];
                        periph_data    <= cpu_wdata;
                        periph_rden    <= cpu_rden & ~cpu_wren;
                        periph_wren    <= cpu_wren;
                        is_read_r      <= cpu_rden & ~cpu_wren;
                        clken_r        <= onehot_s;
                        slot_r         <= dec_slot_s;
                        mapped_r       <= dec_in_range_s;
                        state_r        <= ACCESS;
                    end
                end
                ACCESS: begin
                    periph_rden <= 1'b0;
                    periph_wren <= 1'b0;
                    clken_r     <= {NSLOTS{1'b0}};
                    state_r     <= CAPTURE;
                end
                CAPTURE: begin
                    if (is_read_r) begin
                        cpu_rdata <= mapped_r ? q_sel_s : UNMAPPED_RDATA;
                    end
                    cpu_ready <= 1'b1;
                    cpu_err   <= ERR_EN_P & ~mapped_r;
                    state_r   <= DONE;
                end
                DONE: begin
                    cpu_ready <= 1'b0;
                    cpu_err   <= 1'b0;
                    state_r   <= IDLE;
                end
                default: begin
                    periph_rden <= 1'b0;
                    periph_wren <= 1'b0;
                    clken_r     <= {NSLOTS{1'b0}};
                    cpu_ready   <= 1'b0;
                    cpu_err     <= 1'b0;
                    state_r     <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_periph_bus_bridge.sv
// Scoreboard bench for periph_bus_bridge: directed accesses push expected
// responses, a negedge monitor checks each cpu_ready pulse against them.
module tb_periph_bus_bridge;

    localparam int NSLOTS = 4;

`ifdef PBRIDGE_BUSERR_EN
    localparam logic        UNM_ERR  = 1'b1;
    localparam logic [31:0] UNM_DATA = 32'hDEAD_BEEF;
`else
    localparam logic        UNM_ERR  = 1'b0;
    localparam logic [31:0] UNM_DATA = 32'h0000_0000;
`endif

    logic                   clk = 1'b0;
    logic                   rst = 1'b1;
    logic [31:0]            cpu_addr = 32'h0;
    logic [31:0]            cpu_wdata = 32'h0;
    logic                   cpu_rden = 1'b0;
    logic                   cpu_wren = 1'b0;
    logic [31:0]            cpu_rdata;
    logic                   cpu_ready;
    logic                   cpu_err;
    logic [10:0]            periph_address;
    logic [31:0]            periph_data;
    logic                   periph_rden;
    logic                   periph_wren;
    logic [NSLOTS-1:0]      periph_clken;
    logic [NSLOTS*32-1:0]   periph_q;

    always #5 clk = ~clk;

    periph_bus_bridge #(
        .NSLOTS    (NSLOTS),
        .BASE_ADDR (32'h8000_0000)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .cpu_addr       (cpu_addr),
        .cpu_wdata      (cpu_wdata),
        .cpu_rden       (cpu_rden),
        .cpu_wren       (cpu_wren),
        .cpu_rdata      (cpu_rdata),
        .cpu_ready      (cpu_ready),
        .cpu_err        (cpu_err),
        .periph_address (periph_address),
        .periph_data    (periph_data),
        .periph_rden    (periph_rden),
        .periph_wren    (periph_wren),
        .periph_clken   (periph_clken),
        .periph_q       (periph_q)
    );

    // Slot models: registered q, one cycle after a read strobe with clken.
    logic [31:0] q_r  [NSLOTS];
    logic [31:0] wmem [NSLOTS];

    function automatic logic [31:0] slot_val(input int i);
        case (i)
            0: return 32'h0A0A_0A0A;
            1: return 32'h1234_5678;
            2: return 32'h2222_2222;
            3: return 32'h3333_3333;
            default: return 32'h0000_0000;
        endcase
    endfunction

    always @(posedge clk) begin
        for (int i = 0; i < NSLOTS; i++) begin
            if (rst) begin
                q_r[i]  <= 32'h0;
                wmem[i] <= 32'h0;
            end else begin
                if (periph_clken[i] && periph_rden) q_r[i]  <= slot_val(i);
                if (periph_clken[i] && periph_wren) wmem[i] <= periph_data;
            end
        end
    end

    always_comb begin
        periph_q = '0;
        for (int i = 0; i < NSLOTS; i++) periph_q[32*i +: 32] = q_r[i];
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_vec = 0;
    int n_bad = 0;
    int clken_cycles = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          cyc;
    } exp_t;

    exp_t sb_q[$];

    // Monitor: every ready pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (|periph_clken) clken_cycles++;
        if (cpu_ready === 1'b1) begin
            if (sb_q.size() == 0) begin
                n_vec++;
                n_bad++;
                $display("FAIL unexpected_ready: got ready=1 expected no response (cycle %0d)", cyc);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                chk("ready_cycle", 32'(cyc), 32'(e.cyc));
                chk("cpu_rdata",   cpu_rdata, e.rdata);
                chk("cpu_err",     {31'h0, cpu_err}, {31'h0, e.err});
            end
        end
    end

    task automatic access(input logic [31:0] addr, input logic [31:0] wd,
                          input logic rd, input logic wr,
                          input logic [3:0] exp_clken,
                          input logic [31:0] exp_rdata, input logic exp_err);
        @(posedge clk); #1;
        cpu_addr  = addr;
        cpu_wdata = wd;
        cpu_rden  = rd;
        cpu_wren  = wr;
        sb_q.push_back('{exp_rdata, exp_err, cyc + 3});
        @(posedge clk);
        @(negedge clk);
        chk("acc_clken",   32'(periph_clken), 32'(exp_clken));
        chk("acc_rden",    32'(periph_rden),  32'(rd & ~wr));
        chk("acc_wren",    32'(periph_wren),  32'(wr));
        chk("acc_address", 32'(periph_address), {21'h0, addr[10:0]});
        chk("acc_data",    periph_data, wd);
        @(posedge clk);
        @(negedge clk);
        chk("post_clken", 32'(periph_clken), 32'h0);
        chk("post_strb",  {30'h0, periph_rden, periph_wren}, 32'h0);
        @(posedge clk);
        @(posedge clk); #1;
        cpu_rden = 1'b0;
        cpu_wren = 1'b0;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_ready"}, {31'h0, cpu_ready}, 32'h0);
        chk({tag, "_err"},   {31'h0, cpu_err},   32'h0);
        chk({tag, "_rdata"}, cpu_rdata, 32'h0);
        chk({tag, "_strb"},  {30'h0, periph_rden, periph_wren}, 32'h0);
        chk({tag, "_clken"}, 32'(periph_clken), 32'h0);
        chk({tag, "_addr"},  32'(periph_address), 32'h0);
        chk({tag, "_data"},  periph_data, 32'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not reach its summary");
        $fatal(1);
    end

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_all_zero("reset");
        @(posedge clk); #1;
        rst = 1'b0;

        // Mapped read of slot 1.
        access(32'h8000_0800, 32'h0, 1'b1, 1'b0, 4'b0010, 32'h1234_5678, 1'b0);
        // Mapped write to slot 0; rdata keeps the previous load value.
        access(32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1, 4'b0001, 32'h1234_5678, 1'b0);
        chk("slot0_written", wmem[0], 32'h0000_0001);
        // Unmapped read just past the last slot.
        access(32'h8000_2000, 32'h0, 1'b1, 1'b0, 4'b0000, UNM_DATA, UNM_ERR);
        // rden and wren both high: a write to slot 2, rdata unchanged.
        access(32'h8000_1004, 32'hCAFE_0002, 1'b1, 1'b1, 4'b0100, UNM_DATA, 1'b0);
        chk("slot2_written", wmem[2], 32'hCAFE_0002);
        // Unmapped write just below the base is dropped.
        access(32'h7FFF_FFFC, 32'h0000_AAAA, 1'b0, 1'b1, 4'b0000, UNM_DATA, UNM_ERR);

        // Reset during the ACCESS cycle drops the read.
        @(posedge clk); #1;
        cpu_addr = 32'h8000_1800;
        cpu_rden = 1'b1;
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        chk("rst_access_clken", 32'(periph_clken), 32'h0);
        @(posedge clk); #1;
        rst = 1'b0;
        cpu_rden = 1'b0;
        @(negedge clk);
        chk_all_zero("after_rst");
        repeat (5) @(posedge clk);

        // Normal read after reset, last word of slot 3.
        access(32'h8000_1FFC, 32'h0, 1'b1, 1'b0, 4'b1000, 32'h3333_3333, 1'b0);

        // Held request: two back-to-back reads, ready pulses 4 cycles apart.
        @(posedge clk); #1;
        cpu_addr = 32'h8000_0810;
        cpu_rden = 1'b1;
        sb_q.push_back('{32'h1234_5678, 1'b0, cyc + 3});
        sb_q.push_back('{32'h1234_5678, 1'b0, cyc + 7});
        repeat (8) @(posedge clk);
        #1;
        cpu_rden = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        chk("rdata_held", cpu_rdata, 32'h1234_5678);

        chk("outstanding", 32'(sb_q.size()), 32'h0);
        chk("clken_cycles", 32'(clken_cycles), 32'd6);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
